// File: rtl/minterm_sweep_checker.sv
// Exhaustive minterm sweep checker: drives every input vector, compares the response with a truth table.
// Optional STOP_ON_FAIL_EN macro ends the sweep on the first mismatch.
module minterm_sweep_checker #(
  parameter int unsigned             N      = 3,
  parameter logic [(2**N)-1:0]       DEF_TT = 8'hE2,
  parameter int unsigned             SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tt_load,
  input  logic [(2**N)-1:0]     tt_in,
  input  logic                  start,
  input  logic                  resp,
  output logic [N-1:0]          vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N:0]            err_cnt,
  output logic [N-1:0]          first_fail,
  output logic                  fail_valid
);

  localparam int unsigned NV       = 2**N;
  localparam int unsigned SW       = 4;
  localparam logic [N-1:0] VEC_LAST  = N'(NV - 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [NV-1:0]   tt, tt_d;
  logic [SW-1:0]   settle, settle_d;
  logic [N-1:0]    vec_d, first_fail_d;
  logic [N:0]      err_cnt_d;
  logic            busy_d, done_d, pass_d, fail_valid_d;
  logic            mism;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tt         <= DEF_TT;
      settle     <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_d;
      tt         <= tt_d;
      settle     <= settle_d;
      vec        <= vec_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_cnt_d;
      first_fail <= first_fail_d;
      fail_valid <= fail_valid_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    tt_d         = tt;
    settle_d     = settle;
    vec_d        = vec;
    busy_d       = busy;
    done_d       = done;
    pass_d       = pass;
    err_cnt_d    = err_cnt;
    first_fail_d = first_fail;
    fail_valid_d = fail_valid;
    mism         = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (tt_load) tt_d = tt_in;
        if (start) begin
          state_d      = RUN;
          vec_d        = '0;
          err_cnt_d    = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          settle_d     = SETTLE_LD;
        end
      end
      RUN: begin
        if (settle != '0) begin
          settle_d = settle - SW'(1);
        end else begin
          // Sampling edge: last cycle of this vector's settle window
          mism = (resp != tt[vec]);
          if (mism) begin
            err_cnt_d = err_cnt + (N+1)'(1);
            if (!fail_valid) begin
              first_fail_d = vec;
              fail_valid_d = 1'b1;
            end
          end
`ifdef STOP_ON_FAIL_EN
          if (mism) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = 1'b0;
          end else if (vec == VEC_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_cnt_d == '0);
          end else begin
            vec_d    = vec + N'(1);
            settle_d = SETTLE_LD;
          end
`else
          if (vec == VEC_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (err_cnt_d == '0);
          end else begin
            vec_d    = vec + N'(1);
            settle_d = SETTLE_LD;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
